// File: rtl/video_scanlines.sv
// ---------------------------------------------------------------------------
// video_scanlines
//
// Scanline-darkening stage for the video output path. It sits directly after
// the horizontal blend stage, counts lines within each frame and attenuates
// alternate lines by a selectable amount. Sync and blank are delayed by the
// same single pixel-enable as the RGB, so the outputs can feed the
// scaler/output mux directly.
//
// Optional build macro:
//   VIDEO_SCANLINES_PHASE_EN - adds the 'phase' input. phase is captured at
//                              the start of each frame; when it is 1 the even
//                              lines are dimmed instead of the odd ones. This
//                              suits interlaced or field-shifted sources.
//
// Parameters:
//   LINE_CNT_W  - width of the line counter; the count saturates at all-ones.
//
// Ports:
//   clk          in   video clock
//   reset_n      in   asynchronous active-low reset
//   pix_ce       in   pixel clock enable; nothing advances while low
//   mode[1:0]    in   0 = off, 1 = 25% dim, 2 = 50% dim, 3 = 75% dim
//   hblank       in   horizontal blank, active-high
//   vblank       in   vertical blank, active-high
//   hs, vs       in   horizontal / vertical sync, active-high
//   red/green/blue[7:0]  in  input colour
//   phase        in   (VIDEO_SCANLINES_PHASE_EN only) dim even lines when 1
//   hblank_out, vblank_out, hs_out, vs_out  out  timing delayed one pix_ce
//   red_out/green_out/blue_out[7:0]         out  processed colour
//   line_odd     out  bit 0 of the line count used for the current pixel
// ---------------------------------------------------------------------------
module video_scanlines #(
    parameter int unsigned LINE_CNT_W = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic [1:0] mode,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       hs,
    input  logic       vs,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
`ifdef VIDEO_SCANLINES_PHASE_EN
    input  logic       phase,
`endif
    output logic       hblank_out,
    output logic       vblank_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out,
    output logic       line_odd
);

    localparam logic [LINE_CNT_W-1:0] CntMax = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                  hs_prev_q;
    logic                  vs_prev_q;
    logic [LINE_CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]            mode_lat_q, mode_lat_d;
`ifdef VIDEO_SCANLINES_PHASE_EN
    logic                  phase_lat_q, phase_lat_d;
`endif

    logic       hs_rise;
    logic       vs_rise;
    logic       parity;
    logic       dim;
    logic [7:0] red_d, green_d, blue_d;

    // Attenuate one 8-bit channel. Every result is <= c, so no saturation
    // logic is needed; mode 0 is an exact pass-through.
    function automatic logic [7:0] dim_chan(input logic [7:0] c, input logic [1:0] m);
        logic [7:0] r;
        unique case (m)
            2'd0:    r = c;
            2'd1:    r = c - (c >> 2);
            2'd2:    r = c >> 1;
            default: r = c >> 2;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Edge detection and next-state
    // -----------------------------------------------------------------------
    assign hs_rise = hs & ~hs_prev_q;
    assign vs_rise = vs & ~vs_prev_q;

    always_comb begin
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        // vs wins over a coincident hs so a frame always starts at line 0.
        if (vs_rise) begin
            cnt_d      = '0;
            mode_lat_d = mode;
        end else if (hs_rise && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + LINE_CNT_W'(1);
        end
    end

`ifdef VIDEO_SCANLINES_PHASE_EN
    always_comb begin
        phase_lat_d = phase_lat_q;
        if (vs_rise) begin
            phase_lat_d = phase;
        end
    end

    assign parity = cnt_q[0] ^ phase_lat_q;
`else
    assign parity = cnt_q[0];
`endif

    // The dim decision uses the count and mode from before this pixel's
    // update, so the pixel carrying a sync edge still belongs to the old line.
    assign dim = (mode_lat_q != 2'd0) & parity & ~hblank & ~vblank;

    always_comb begin
        red_d   = red;
        green_d = green;
        blue_d  = blue;
        if (dim) begin
            red_d   = dim_chan(red,   mode_lat_q);
            green_d = dim_chan(green, mode_lat_q);
            blue_d  = dim_chan(blue,  mode_lat_q);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            cnt_q       <= '0;
            mode_lat_q  <= 2'd0;
`ifdef VIDEO_SCANLINES_PHASE_EN
            phase_lat_q <= 1'b0;
`endif
            hblank_out  <= 1'b0;
            vblank_out  <= 1'b0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            red_out     <= 8'd0;
            green_out   <= 8'd0;
            blue_out    <= 8'd0;
            line_odd    <= 1'b0;
        end else if (pix_ce) begin
            hs_prev_q   <= hs;
            vs_prev_q   <= vs;
            cnt_q       <= cnt_d;
            mode_lat_q  <= mode_lat_d;
`ifdef VIDEO_SCANLINES_PHASE_EN
            phase_lat_q <= phase_lat_d;
`endif
            hblank_out  <= hblank;
            vblank_out  <= vblank;
            hs_out      <= hs;
            vs_out      <= vs;
            red_out     <= red_d;
            green_out   <= green_d;
            blue_out    <= blue_d;
            line_odd    <= cnt_q[0];
        end
    end

endmodule

// File: tb/tb_video_scanlines.sv
// ---------------------------------------------------------------------------
// tb_video_scanlines
//
// Directed self-checking bench for video_scanlines. Each pixel is clocked with
// a single pix_ce pulse and the registered outputs are sampled 1 time unit
// after the rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_video_scanlines;

    logic       clk;
    logic       reset_n;
    logic       pix_ce;
    logic [1:0] mode;
    logic       hblank, vblank, hs, vs;
    logic [7:0] red, green, blue;
`ifdef VIDEO_SCANLINES_PHASE_EN
    logic       phase;
`endif
    logic       hblank_out, vblank_out, hs_out, vs_out;
    logic [7:0] red_out, green_out, blue_out;
    logic       line_odd;

    int n_cmp;
    int n_err;

    video_scanlines #(
        .LINE_CNT_W(11)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_ce    (pix_ce),
        .mode      (mode),
        .hblank    (hblank),
        .vblank    (vblank),
        .hs        (hs),
        .vs        (vs),
        .red       (red),
        .green     (green),
        .blue      (blue),
`ifdef VIDEO_SCANLINES_PHASE_EN
        .phase     (phase),
`endif
        .hblank_out(hblank_out),
        .vblank_out(vblank_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .line_odd  (line_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One pixel: a single pix_ce pulse, then sample just after the edge.
    task automatic step();
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
    endtask

    task automatic new_frame(input logic [1:0] m);
        mode = m;
        vs   = 1'b1;
        step();
        vs   = 1'b0;
        step();
    endtask

    task automatic next_line();
        hs = 1'b1;
        step();
        hs = 1'b0;
        step();
    endtask

    logic [7:0] mode_exp [4];
    logic [1:0] mode_seq [4];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b1;
        pix_ce  = 1'b0;
        mode    = 2'd0;
        hblank  = 1'b0;
        vblank  = 1'b0;
        hs      = 1'b0;
        vs      = 1'b0;
        red     = 8'h00;
        green   = 8'h00;
        blue    = 8'h00;
`ifdef VIDEO_SCANLINES_PHASE_EN
        phase   = 1'b0;
`endif
        mode_seq[0] = 2'd1; mode_exp[0] = 8'hC0;
        mode_seq[1] = 2'd2; mode_exp[1] = 8'h7F;
        mode_seq[2] = 2'd3; mode_exp[2] = 8'h3F;
        mode_seq[3] = 2'd0; mode_exp[3] = 8'hFF;

        // Reset state.
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_red",      32'(red_out),   32'h0);
        check_eq("rst_hs_out",   32'(hs_out),    32'h0);
        check_eq("rst_line_odd", 32'(line_odd),  32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Mode 2, vs pulse, then three hs pulses.
        red  = 8'hC8;
        mode = 2'd2;
        vs   = 1'b1;
        step();
        check_eq("vs_out_delay", 32'(vs_out), 32'h1);
        vs = 1'b0;
        step();
        check_eq("l0_red",  32'(red_out),  32'hC8);
        check_eq("l0_odd",  32'(line_odd), 32'h0);
        hs = 1'b1;
        step();
        check_eq("hs_out_delay", 32'(hs_out), 32'h1);
        hs = 1'b0;
        step();
        check_eq("l1_red",  32'(red_out),  32'h64);
        check_eq("l1_odd",  32'(line_odd), 32'h1);
        next_line();
        check_eq("l2_red",  32'(red_out),  32'hC8);
        check_eq("l2_odd",  32'(line_odd), 32'h0);
        next_line();
        check_eq("l3_red",  32'(red_out),  32'h64);

        // Per-mode arithmetic on an odd line.
        red   = 8'h00;
        green = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            new_frame(mode_seq[i]);
            next_line();
            check_eq($sformatf("mode%0d_green", mode_seq[i]), 32'(green_out), 32'(mode_exp[i]));
        end

        // Mode change mid-frame waits for the next vs edge.
        new_frame(2'd2);
        next_line();
        mode = 2'd3;
        step();
        check_eq("midframe_l1", 32'(green_out), 32'h7F);
        next_line();
        next_line();
        check_eq("midframe_l3", 32'(green_out), 32'h7F);
        new_frame(2'd3);
        next_line();
        check_eq("nextframe_l1", 32'(green_out), 32'h3F);

        // Coincident hs and vs rising: counter restarts at 0.
        hs = 1'b1;
        vs = 1'b1;
        step();
        hs = 1'b0;
        vs = 1'b0;
        step();
        check_eq("hsvs_green", 32'(green_out), 32'hFF);
        check_eq("hsvs_odd",   32'(line_odd),  32'h0);

        // Blanked pixels on an odd line are never dimmed.
        next_line();
        blue   = 8'h80;
        hblank = 1'b1;
        step();
        check_eq("hblank_blue", 32'(blue_out), 32'h80);
        check_eq("hblank_out",  32'(hblank_out), 32'h1);
        hblank = 1'b0;
        vblank = 1'b1;
        step();
        check_eq("vblank_blue", 32'(blue_out), 32'h80);
        vblank = 1'b0;
        step();
        check_eq("active_blue", 32'(blue_out), 32'h20);

        // pix_ce low for 5 clocks while inputs toggle: everything holds.
        red = 8'hC8;
        step();
        check_eq("pre_hold_red", 32'(red_out), 32'h32);
        for (int i = 0; i < 5; i++) begin
            hs  = ~hs;
            vs  = ~vs;
            red = red + 8'h11;
            @(posedge clk);
            #1;
            check_eq($sformatf("hold_red%0d", i), 32'(red_out),  32'h32);
            check_eq($sformatf("hold_hs%0d", i),  32'(hs_out),   32'h0);
            check_eq($sformatf("hold_odd%0d", i), 32'(line_odd), 32'h1);
        end
        hs  = 1'b0;
        vs  = 1'b0;
        red = 8'hC8;
        step();
        check_eq("post_hold_red", 32'(red_out),  32'h32);
        check_eq("post_hold_odd", 32'(line_odd), 32'h1);

        // Asynchronous reset mid-frame, sampled before the next clock edge.
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_red",   32'(red_out),   32'h0);
        check_eq("async_green", 32'(green_out), 32'h0);
        check_eq("async_blue",  32'(blue_out),  32'h0);
        check_eq("async_odd",   32'(line_odd),  32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        check_eq("post_rst_red", 32'(red_out), 32'hC8);

`ifdef VIDEO_SCANLINES_PHASE_EN
        // phase=1 latched at vs: even lines are dimmed.
        phase = 1'b1;
        new_frame(2'd2);
        check_eq("phase_l0_red", 32'(red_out), 32'h64);
        next_line();
        check_eq("phase_l1_red", 32'(red_out), 32'hC8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_scanlines.md
Name: video_scanlines

Overview:
- Scanline-darkening stage placed directly downstream of the horizontal blend stage in the video output path.
- Consumes that stage's blended RGB, blanking and sync signals.
- Counts lines within each frame and attenuates alternate lines by a selectable amount.
- Outputs retimed video with sync and blank delayed to match the RGB, so the result feeds the scaler/output mux directly.

Parameters:
- LINE_CNT_W, 11, width of the line counter; the counter saturates at 2^LINE_CNT_W-1.

Ports:
- clk  in  1  video clock.
- reset_n  in  1  asynchronous active-low reset.
- pix_ce  in  1  pixel clock enable; all state advances only when high.
- mode  in  2  0=off, 1=25% dim, 2=50% dim, 3=75% dim.
- hblank, vblank, hs, vs  in  1 each  input timing, active-high.
- red, green, blue  in  8 each  input colour.
- hblank_out, vblank_out, hs_out, vs_out  out  1 each  timing delayed 1 pix_ce.
- red_out, green_out, blue_out  out  8 each  processed colour.
- line_odd  out  1  bit0 of the line counter used for the current output pixel.

Behaviour:
- Reset (reset_n=0, asynchronous): every output = 0. Line counter = 0, hs_prev = 0, vs_prev = 0, mode_lat = 0. Takes effect immediately, mid-line or mid-frame.
- All registers other than the reset path update only on clk rising edges with pix_ce=1. With pix_ce=0, all state and outputs hold.
- Latency: exactly 1 pix_ce for every output. Timing outputs are the inputs registered unchanged.
- Edge detect: hs_rise = hs & ~hs_prev; vs_rise = vs & ~vs_prev. hs_prev and vs_prev are updated every pix_ce.
- Line counter:
  - On vs_rise: counter <= 0.
  - Else on hs_rise: counter <= counter+1, saturating at max (no wrap).
  - vs_rise and hs_rise on the same pix_ce: vs_rise wins, counter = 0.
- mode_lat <= mode on vs_rise only, so a change mid-frame takes effect from the next frame.
- Dim decision uses the counter value *before* this pix_ce's update: dim = (mode_lat != 0) & cnt[0] & ~hblank & ~vblank. line_odd <= cnt[0].
- Per channel c (8-bit, all right shifts logical, results truncated):
  - mode 1: c - (c>>2)
  - mode 2: c>>1
  - mode 3: c>>2
  - not dim: c unchanged
- No overflow is possible; every result is ≤ c.
- Blanked pixels pass through unmodified, never dimmed.
- Mode 0 gives bit-exact pass-through, delayed 1 pix_ce.

Optional Feature:
- Macro: VIDEO_SCANLINES_PHASE_EN.
- Defined:
  - Adds input port phase (1 bit); phase_lat <= phase on vs_rise, reset 0.
  - Dim parity term becomes (cnt[0] ^ phase_lat). phase_lat=1 dims even lines instead of odd.
  - Supports interlaced/field-shifted sources.
- Undefined:
  - No phase port.
  - Parity term is cnt[0]; odd lines (1,3,5,...) are dimmed.

Test Plan:
- Reset released, mode=2, vs pulse, then 3 hs pulses; red=0xC8, blanks low. Required red_out: 0xC8 on line 0, 0x64 on line 1, 0xC8 on line 2. line_odd follows 0/1/0.
- Mode arithmetic on an odd line with green=0xFF. Required green_out: mode1 0xC0, mode2 0x7F, mode3 0x3F, mode0 0xFF.
- mode changed 2→3 mid-frame on line 1. Required: dimming stays 50% until the next vs rising edge, then 75% on odd lines.
- hs and vs rising on the same pix_ce. Required: counter=0 and the next line is not dimmed. Blanked odd-line pixels (hblank=1, blue=0x80) output 0x80.
- pix_ce low for 5 clks mid-line with inputs toggling. Required: outputs and counter hold. Then assert reset_n=0 mid-frame: all outputs 0 immediately, without waiting for a clk edge.
- With VIDEO_SCANLINES_PHASE_EN defined and phase=1 latched at vs. Required: line 0 red=0xC8 → 0x64; line 1 → 0xC8.
